// File: rtl/obstacle_collision_monitor_if.sv
// Obstacle/dino bounding-box bus into the collision monitor, plus its result flags.
interface obstacle_collision_monitor_if;
    logic               FrameClk;
    logic [1:0]         gameState;
    logic signed [31:0] DinoX;
    logic signed [31:0] DinoY;
    logic [11:0]        DinoW;
    logic [11:0]        DinoH;
    logic signed [31:0] ObstacleY;
    logic signed [31:0] Obs1_X;
    logic signed [31:0] Obs2_X;
    logic signed [31:0] Obs3_X;
    logic [11:0]        Obs1_W;
    logic [11:0]        Obs2_W;
    logic [11:0]        Obs3_W;
    logic [11:0]        Obs1_H;
    logic [11:0]        Obs2_H;
    logic [11:0]        Obs3_H;
    logic               collision;
    logic               collisionPulse;
    logic [1:0]         hitIndex;
    logic               checkDone;
    logic [3:0]         hitStreak;

    modport master (
        output FrameClk, gameState, DinoX, DinoY, DinoW, DinoH, ObstacleY,
               Obs1_X, Obs2_X, Obs3_X, Obs1_W, Obs2_W, Obs3_W, Obs1_H, Obs2_H, Obs3_H,
        input  collision, collisionPulse, hitIndex, checkDone, hitStreak
    );

    modport slave (
        input  FrameClk, gameState, DinoX, DinoY, DinoW, DinoH, ObstacleY,
               Obs1_X, Obs2_X, Obs3_X, Obs1_W, Obs2_W, Obs3_W, Obs1_H, Obs2_H, Obs3_H,
        output collision, collisionPulse, hitIndex, checkDone, hitStreak
    );
endinterface

// File: rtl/obstacle_collision_monitor.sv
// Per-frame dino/obstacle overlap check with hit-streak debounce and sticky collision flag.
module obstacle_collision_monitor #(
    parameter int          ScreenW    = 640,
    parameter int          MARGIN     = 2,
    parameter int unsigned HIT_FRAMES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    obstacle_collision_monitor_if.slave bus
);
    localparam int unsigned PosW  = 32;
    localparam int unsigned DimW  = 12;
    localparam int unsigned StrkW = 4;
    localparam int unsigned NObs  = 3;
    localparam logic signed [PosW-1:0] MarginS = PosW'(MARGIN);
    localparam logic signed [PosW-1:0] ScreenS = PosW'(ScreenW);
    localparam logic signed [PosW-1:0] ZeroS   = '0;
    localparam logic [DimW-1:0]        MinDim  = DimW'(2 * MARGIN);
    localparam logic [StrkW-1:0]       StrkMax = '1;
    localparam logic [StrkW-1:0]       HitThr  = StrkW'(HIT_FRAMES);

    typedef enum logic [2:0] {IDLE, CHK1, CHK2, CHK3, RESOLVE} state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic                   frame_edge;
    logic [1:0]             snap_gs_q, snap_gs_d;
    logic signed [PosW-1:0] snap_dx_q, snap_dx_d, snap_dy_q, snap_dy_d, snap_oy_q, snap_oy_d;
    logic [DimW-1:0]        snap_dw_q, snap_dw_d, snap_dh_q, snap_dh_d;
    logic signed [PosW-1:0] snap_ox_q [NObs];
    logic signed [PosW-1:0] snap_ox_d [NObs];
    logic [DimW-1:0]        snap_ow_q [NObs];
    logic [DimW-1:0]        snap_ow_d [NObs];
    logic [DimW-1:0]        snap_oh_q [NObs];
    logic [DimW-1:0]        snap_oh_d [NObs];
    logic signed [PosW-1:0] obs_x [NObs];
    logic [DimW-1:0]        obs_w [NObs];
    logic [DimW-1:0]        obs_h [NObs];
    logic [NObs-1:0]        ovl_q, ovl_d;
    logic                   collision_q, collision_d, pulse_q, pulse_d, done_q, done_d;
    logic [1:0]             hit_idx_q, hit_idx_d;
    logic [StrkW-1:0]       streak_q, streak_d;
    logic signed [PosW-1:0] chk_ox;
    logic [DimW-1:0]        chk_ow, chk_oh;
    logic                   chk_ovl;

    // Shrunken-hitbox overlap test with strict compares so touching edges never count.
    function automatic logic overlap_f(
        input logic signed [PosW-1:0] ox,
        input logic [DimW-1:0]        ow,
        input logic [DimW-1:0]        oh,
        input logic signed [PosW-1:0] oy,
        input logic signed [PosW-1:0] dx,
        input logic signed [PosW-1:0] dy,
        input logic [DimW-1:0]        dw,
        input logic [DimW-1:0]        dh
    );
        logic signed [PosW-1:0] ow_s, oh_s, dw_s, dh_s;
        logic signed [PosW-1:0] left, right, top, bottom;
        logic present, has_box, dino_ok, x_hit, y_hit;
        ow_s    = $signed(PosW'(ow));
        oh_s    = $signed(PosW'(oh));
        dw_s    = $signed(PosW'(dw));
        dh_s    = $signed(PosW'(dh));
        left    = ox + MarginS;
        right   = ox + ow_s - MarginS;
        top     = oy + MarginS;
        bottom  = oy + oh_s - MarginS;
        present = (ox <= ScreenS) && ((ox + ow_s) > ZeroS);
        has_box = (ow > MinDim) && (oh > MinDim);
        dino_ok = (dw != '0) && (dh != '0);
        x_hit   = (dx < right) && (left < (dx + dw_s));
        y_hit   = (dy < bottom) && (top < (dy + dh_s));
        return present && has_box && dino_ok && x_hit && y_hit;
    endfunction

    assign obs_x[0] = bus.Obs1_X;
    assign obs_x[1] = bus.Obs2_X;
    assign obs_x[2] = bus.Obs3_X;
    assign obs_w[0] = bus.Obs1_W;
    assign obs_w[1] = bus.Obs2_W;
    assign obs_w[2] = bus.Obs3_W;
    assign obs_h[0] = bus.Obs1_H;
    assign obs_h[1] = bus.Obs2_H;
    assign obs_h[2] = bus.Obs3_H;

    assign frame_edge = sync2_q & ~edge_q;

    // Select the snapshotted obstacle for the current check slot and evaluate it.
    always_comb begin
        chk_ox = snap_ox_q[0];
        chk_ow = snap_ow_q[0];
        chk_oh = snap_oh_q[0];
        case (state_q)
            CHK2: begin
                chk_ox = snap_ox_q[1];
                chk_ow = snap_ow_q[1];
                chk_oh = snap_oh_q[1];
            end
            CHK3: begin
                chk_ox = snap_ox_q[2];
                chk_ow = snap_ow_q[2];
                chk_oh = snap_oh_q[2];
            end
            default: ;
        endcase
        chk_ovl = overlap_f(chk_ox, chk_ow, chk_oh, snap_oy_q,
                            snap_dx_q, snap_dy_q, snap_dw_q, snap_dh_q);
    end

    // Next-state, snapshot capture, streak/collision resolution and live idle clear.
    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.FrameClk;
        sync2_d     = sync1_q;
        edge_d      = sync2_q;
        snap_gs_d   = snap_gs_q;
        snap_dx_d   = snap_dx_q;
        snap_dy_d   = snap_dy_q;
        snap_dw_d   = snap_dw_q;
        snap_dh_d   = snap_dh_q;
        snap_oy_d   = snap_oy_q;
        snap_ox_d   = snap_ox_q;
        snap_ow_d   = snap_ow_q;
        snap_oh_d   = snap_oh_q;
        ovl_d       = ovl_q;
        collision_d = collision_q;
        hit_idx_d   = hit_idx_q;
        streak_d    = streak_q;
        pulse_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    snap_gs_d = bus.gameState;
                    snap_dx_d = bus.DinoX;
                    snap_dy_d = bus.DinoY;
                    snap_dw_d = bus.DinoW;
                    snap_dh_d = bus.DinoH;
                    snap_oy_d = bus.ObstacleY;
                    snap_ox_d = obs_x;
                    snap_ow_d = obs_w;
                    snap_oh_d = obs_h;
                    state_d   = CHK1;
                end
            end
            CHK1: begin
                ovl_d[0] = chk_ovl;
                state_d  = CHK2;
            end
            CHK2: begin
                ovl_d[1] = chk_ovl;
                state_d  = CHK3;
            end
            CHK3: begin
                ovl_d[2] = chk_ovl;
                state_d  = RESOLVE;
            end
            RESOLVE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (snap_gs_q == 2'b01) begin
                    if (|ovl_q) begin
                        streak_d = (streak_q == StrkMax) ? StrkMax : StrkW'(streak_q + 1'b1);
                    end else begin
                        streak_d = '0;
                    end
                    if ((streak_d >= HitThr) && !collision_q) begin
                        collision_d = 1'b1;
                        pulse_d     = 1'b1;
                        hit_idx_d   = ovl_q[0] ? 2'd1 : (ovl_q[1] ? 2'd2 : 2'd3);
                    end
                end else begin
                    streak_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.gameState == 2'b00) begin
            collision_d = 1'b0;
            hit_idx_d   = '0;
            streak_d    = '0;
            pulse_d     = 1'b0;
        end
    end

    // State, synchroniser, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            snap_gs_q   <= '0;
            snap_dx_q   <= '0;
            snap_dy_q   <= '0;
            snap_dw_q   <= '0;
            snap_dh_q   <= '0;
            snap_oy_q   <= '0;
            for (int i = 0; i < int'(NObs); i++) begin
                snap_ox_q[i] <= '0;
                snap_ow_q[i] <= '0;
                snap_oh_q[i] <= '0;
            end
            ovl_q       <= '0;
            collision_q <= 1'b0;
            hit_idx_q   <= '0;
            streak_q    <= '0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            snap_gs_q   <= snap_gs_d;
            snap_dx_q   <= snap_dx_d;
            snap_dy_q   <= snap_dy_d;
            snap_dw_q   <= snap_dw_d;
            snap_dh_q   <= snap_dh_d;
            snap_oy_q   <= snap_oy_d;
            snap_ox_q   <= snap_ox_d;
            snap_ow_q   <= snap_ow_d;
            snap_oh_q   <= snap_oh_d;
            ovl_q       <= ovl_d;
            collision_q <= collision_d;
            hit_idx_q   <= hit_idx_d;
            streak_q    <= streak_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
        end
    end

    assign bus.collision      = collision_q;
    assign bus.collisionPulse = pulse_q;
    assign bus.hitIndex       = hit_idx_q;
    assign bus.checkDone      = done_q;
    assign bus.hitStreak      = streak_q;
endmodule

// File: tb/tb_obstacle_collision_monitor.sv
// Directed-vector bench for obstacle_collision_monitor.
module tb_obstacle_collision_monitor;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    obstacle_collision_monitor_if ifc();

    obstacle_collision_monitor #(
        .ScreenW   (640),
        .MARGIN    (2),
        .HIT_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    // Single comparison point: count it and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dino(input int x, input int y, input int w, input int h);
        ifc.DinoX = x;
        ifc.DinoY = y;
        ifc.DinoW = 12'(w);
        ifc.DinoH = 12'(h);
    endtask

    task automatic set_obs(input int n, input int x, input int w, input int h);
        case (n)
            1: begin ifc.Obs1_X = x; ifc.Obs1_W = 12'(w); ifc.Obs1_H = 12'(h); end
            2: begin ifc.Obs2_X = x; ifc.Obs2_W = 12'(w); ifc.Obs2_H = 12'(h); end
            default: begin ifc.Obs3_X = x; ifc.Obs3_W = 12'(w); ifc.Obs3_H = 12'(h); end
        endcase
    endtask

    task automatic clear_obs();
        set_obs(1, 1000, 20, 30);
        set_obs(2, 1000, 20, 30);
        set_obs(3, 1000, 20, 30);
    endtask

    // Raise FrameClk at a negedge and watch a bounded window for the check result.
    task automatic run_frame(output int lat, output int ndone, output int npulse);
        lat    = -1;
        ndone  = 0;
        npulse = 0;
        @(negedge clk);
        ifc.FrameClk = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ifc.checkDone) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (ifc.collisionPulse) npulse++;
        end
        ifc.FrameClk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One frame plus the full set of result checks.
    task automatic frame_chk(input string tag, input int e_streak, input int e_col,
                             input int e_idx, input int e_pulse);
        int lat, ndone, npulse;
        run_frame(lat, ndone, npulse);
        chk({tag, ".lat"},    32'(lat), 32'd7);
        chk({tag, ".ndone"},  32'(ndone), 32'd1);
        chk({tag, ".pulse"},  32'(npulse), 32'(e_pulse));
        chk({tag, ".streak"}, 32'(ifc.hitStreak), 32'(e_streak));
        chk({tag, ".col"},    32'(ifc.collision), 32'(e_col));
        chk({tag, ".idx"},    32'(ifc.hitIndex), 32'(e_idx));
    endtask

    task automatic idle_clear(input string tag);
        @(negedge clk);
        ifc.gameState = 2'b00;
        @(negedge clk);
        ifc.gameState = 2'b01;
        chk({tag, ".col"},    32'(ifc.collision), 32'd0);
        chk({tag, ".idx"},    32'(ifc.hitIndex), 32'd0);
        chk({tag, ".streak"}, 32'(ifc.hitStreak), 32'd0);
    endtask

    initial begin
        int ndone;
        int lat;
        rst           = 1'b1;
        ifc.FrameClk  = 1'b0;
        ifc.gameState = 2'b01;
        ifc.ObstacleY = 210;
        set_dino(100, 200, 40, 40);
        clear_obs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.col",    32'(ifc.collision), 32'd0);
        chk("rst.pulse",  32'(ifc.collisionPulse), 32'd0);
        chk("rst.idx",    32'(ifc.hitIndex), 32'd0);
        chk("rst.done",   32'(ifc.checkDone), 32'd0);
        chk("rst.streak", 32'(ifc.hitStreak), 32'd0);

        // Basic two-frame debounce to collision on obstacle 1.
        set_obs(1, 120, 20, 30);
        frame_chk("f1", 1, 0, 0, 0);
        frame_chk("f2", 2, 1, 1, 1);
        idle_clear("clr1");

        // Overlap, gap, overlap: streak restarts and no collision.
        frame_chk("gap1", 1, 0, 0, 0);
        set_obs(1, 1000, 20, 30);
        frame_chk("gap2", 0, 0, 0, 0);
        set_obs(1, 120, 20, 30);
        frame_chk("gap3", 1, 0, 0, 0);

        // Off-screen right (X = ScreenW+1) overlapping numerically: absent.
        clear_obs();
        set_dino(630, 200, 40, 40);
        set_obs(3, 641, 20, 30);
        frame_chk("offR", 0, 0, 0, 0);
        // Fully left of screen (X+W <= 0) overlapping numerically: absent.
        clear_obs();
        set_dino(-40, 200, 40, 40);
        set_obs(2, -30, 20, 30);
        frame_chk("offL", 0, 0, 0, 0);
        // X exactly at ScreenW is still present.
        clear_obs();
        set_dino(630, 200, 40, 40);
        set_obs(1, 640, 20, 30);
        frame_chk("edgeR", 1, 0, 0, 0);
        // Shrunken left edge exactly at DinoX+DinoW: touching, no overlap.
        set_dino(100, 200, 40, 40);
        set_obs(1, 138, 20, 30);
        frame_chk("touch", 0, 0, 0, 0);
        // One pixel further in overlaps.
        set_obs(1, 137, 20, 30);
        frame_chk("in1", 1, 0, 0, 0);
        // Obstacles 2 and 3 both overlapping: lowest index wins.
        clear_obs();
        set_obs(2, 120, 20, 30);
        set_obs(3, 120, 20, 30);
        frame_chk("tie", 2, 1, 2, 1);

        // Game over: overlaps ignored, flag held, streak cleared.
        ifc.gameState = 2'b10;
        frame_chk("over", 0, 1, 2, 0);
        ifc.gameState = 2'b01;
        // Already collided: no new pulse, index held, streak still tracks.
        clear_obs();
        set_obs(1, 120, 20, 30);
        frame_chk("held", 1, 1, 2, 0);
        idle_clear("clr2");

        // Second FrameClk rise while a check is in flight is dropped.
        clear_obs();
        ndone = 0;
        lat   = -1;
        @(negedge clk);
        ifc.FrameClk = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2) ifc.FrameClk = 1'b0;
            if (i == 4) ifc.FrameClk = 1'b1;
            if (ifc.checkDone) begin
                ndone++;
                if (lat < 0) lat = i;
            end
        end
        ifc.FrameClk = 1'b0;
        repeat (4) @(negedge clk);
        chk("drop.ndone",  32'(ndone), 32'd1);
        chk("drop.lat",    32'(lat), 32'd7);
        chk("drop.streak", 32'(ifc.hitStreak), 32'd0);

        // Reset in the middle of a check: immediate clear, no checkDone.
        set_obs(1, 120, 20, 30);
        frame_chk("pre1", 1, 0, 0, 0);
        frame_chk("pre2", 2, 1, 1, 1);
        ndone = 0;
        @(negedge clk);
        ifc.FrameClk = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 4) begin
                rst          = 1'b1;
                ifc.FrameClk = 1'b0;
                #1;
                chk("mrst.col",    32'(ifc.collision), 32'd0);
                chk("mrst.idx",    32'(ifc.hitIndex), 32'd0);
                chk("mrst.streak", 32'(ifc.hitStreak), 32'd0);
                chk("mrst.pulse",  32'(ifc.collisionPulse), 32'd0);
            end
            if (i == 5) rst = 1'b0;
            if (ifc.checkDone) ndone++;
        end
        chk("mrst.ndone", 32'(ndone), 32'd0);
        chk("mrst.col2",  32'(ifc.collision), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/obstacle_collision_monitor.md
Name: obstacle_collision_monitor

Overview:
- Consumer end of the obstacle interface: takes the three obstacle bounding boxes (X, W, H plus shared ObstacleY) and the dino bounding box, and decides once per frame whether the dino hit an obstacle.
- Sits between the obstacle delegate/dino logic and the game-state controller; its collision flag drives the transition to game-over.
- Works in the clk domain. FrameClk is synchronised and edge-detected, then obstacles are checked one per cycle, followed by a debounce.

Parameters:
- ScreenW, 640, right screen bound in pixels; an obstacle is present only if X <= ScreenW.
- MARGIN, 2, hitbox shrink in pixels applied to every side of each obstacle box.
- HIT_FRAMES, 2, consecutive overlapping frames required to declare a collision (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- FrameClk  input  1  frame clock, asynchronous to clk; its rising edge starts a check
- gameState  input  2  00 idle, 01 playing, 10 over, 11 reserved (treated as over)
- DinoX  input  32  dino left edge, two's complement
- DinoY  input  32  dino top edge, two's complement
- DinoW  input  12  dino width
- DinoH  input  12  dino height
- ObstacleY  input  32  shared obstacle top edge
- Obs1_X, Obs2_X, Obs3_X  input  32 each  obstacle left edges, two's complement
- Obs1_W, Obs2_W, Obs3_W  input  12 each  obstacle widths
- Obs1_H, Obs2_H, Obs3_H  input  12 each  obstacle heights
- collision  output  1  sticky collision flag
- collisionPulse  output  1  one-cycle pulse when collision first sets
- hitIndex  output  2  obstacle that caused the collision (1..3); 0 = none
- checkDone  output  1  one-cycle pulse at the end of every frame check
- hitStreak  output  4  current count of consecutive overlapping frames (saturating)

Behaviour:
- Reset values (async on rst high): all outputs 0, FSM in IDLE, synchroniser and edge flops 0.
- FrameClk synchronisation:
  - Two flops, then an edge register.
  - frameEdge = sync2 & ~edgeReg.
  - A FrameClk rise is therefore seen 2-3 clk cycles later.
- FSM: IDLE -> CHK1 -> CHK2 -> CHK3 -> RESOLVE -> IDLE.
  - IDLE: on frameEdge, snapshot every Dino, Obs and gameState input into registers, then go to CHK1.
  - CHKn: evaluate obstacle n from the snapshot and register overlap[n].
  - RESOLVE: update streak and collision; checkDone = 1 on the edge leaving RESOLVE.
  - Latency from the snapshot edge to checkDone: 4 cycles, fixed.
  - A frameEdge while not in IDLE is dropped; it is not queued.
- Arithmetic:
  - Positions are signed 32-bit.
  - W and H are zero-extended to 32 bits before any add.
  - No saturation; wrap is permitted and not checked.
- Present check for obstacle n: X <= ScreenW, and X + W > 0 (signed).
- Effective obstacle box:
  - Left = X + MARGIN, right = X + W - MARGIN, top = ObstacleY + MARGIN, bottom = ObstacleY + H - MARGIN.
  - If W <= 2·MARGIN or H <= 2·MARGIN, the obstacle has no hitbox and overlap = 0.
- overlap[n] is asserted only when all of the following hold (strict compares, so touching edges do not count):
  - the obstacle is present and has a hitbox;
  - DinoW != 0 and DinoH != 0;
  - DinoX < right and left < DinoX + DinoW;
  - DinoY < bottom and top < DinoY + DinoH.
- RESOLVE, when the snapshot gameState == 01:
  - Any overlap: hitStreak increments, saturating at 15. No overlap: hitStreak goes to 0.
  - If the new hitStreak >= HIT_FRAMES and collision == 0: set collision, pulse collisionPulse for 1 cycle, and set hitIndex to the lowest overlapping n.
  - Once collision is set: no further pulses, hitIndex is held, hitStreak still tracks.
- RESOLVE, when the snapshot gameState != 01: overlaps are forced to 0, hitStreak goes to 0, collision and hitIndex are held, and checkDone still pulses.
- Live gameState == 00, any cycle, any state:
  - Synchronously clears collision, hitIndex and hitStreak.
  - Overrides any RESOLVE update in the same cycle; collisionPulse is suppressed.
  - The FSM continues its sequence.
- rst mid-check: the FSM returns to IDLE immediately; no checkDone is produced for that frame.
- Simultaneous overlap of several obstacles: hitIndex reports the lowest index; this is a tie-break only.

Test Plan:
- Dino(100,200,40,40), obstacle 1 (120,210,20,30), gameState 01, HIT_FRAMES 2, two FrameClk rises -> frame 1: checkDone, hitStreak=1, collision=0; frame 2: collisionPulse one cycle, collision=1, hitIndex=1; checkDone 4 cycles after each snapshot.
- Overlap on frame 1, none on frame 2, overlap on frame 3 -> hitStreak 1,0,1; collision stays 0.
- Obstacle 3 with X=ScreenW+1 overlapping the dino numerically, and obstacle 2 with X=-30, W=20 -> no overlap, hitStreak=0.
- Touching edge (obstacle left = DinoX+DinoW after margin) -> no overlap. Obstacles 2 and 3 overlapping simultaneously -> hitIndex=2.
- Collision set, then gameState 00 for one cycle -> collision, hitIndex, hitStreak = 0 the next cycle. Overlap while gameState 10 -> checkDone pulses, collision unchanged.
- FrameClk rising again during CHK2 -> ignored, exactly one checkDone. rst asserted in CHK2 -> all outputs 0 immediately, no checkDone.
